// File: rtl/afc_pkg.sv
// Shared types and defaults for the ETROC2 PLL automatic frequency calibration engine.
// Holds the FSM state enum, default widths and a latency helper.
package afc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    COUNT,
    DECIDE
  } afc_state_e;

  localparam int AFC_CODE_W = 9;
  localparam int AFC_CNT_W  = 10;
  localparam logic [8:0] AFC_RESET_CODE = 9'h100;

  function automatic int afc_latency(
    input int code_w,
    input int settle,
    input int window
  );
    return code_w * (settle + window + 1);
  endfunction

endpackage

// File: rtl/afc_freq_counter.sv
// Counting-window timer and saturating feedback-pulse counter.
// Clear zeroes both; enable advances the window and counts pulses.
module afc_freq_counter
  import afc_pkg::*;
#(
  parameter int CNT_W  = AFC_CNT_W,
  parameter int WINDOW = 512
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             enable_i,
  input  logic             pulse_i,
  output logic             window_done_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int TW = (WINDOW > 1) ? $clog2(WINDOW) : 1;

  logic [TW-1:0]    timer_q, timer_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    timer_d = timer_q;
    count_d = count_q;
    if (clear_i) begin
      timer_d = '0;
      count_d = '0;
    end else if (enable_i) begin
      timer_d = timer_q + 1'b1;
      // Saturate rather than wrap so a very fast VCO still reads as fast
      if (pulse_i && (count_q != '1)) begin
        count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q <= '0;
      count_q <= '0;
    end else begin
      timer_q <= timer_d;
      count_q <= count_d;
    end
  end

  assign window_done_o = enable_i && (timer_q == TW'(WINDOW - 1));
  assign count_o       = count_q;

endmodule

// File: rtl/afc_controller.sv
// SAR search over the VCO capacitor-bank code, one bit per settle/count/decide trial.
// cap_code and afc_busy feed the bit protector, which latches the code as busy falls.
module afc_controller
  import afc_pkg::*;
#(
  parameter int CODE_W     = AFC_CODE_W,
  parameter int CNT_W      = AFC_CNT_W,
  parameter int SETTLE_CYC = 64,
  parameter int WINDOW     = 512,
  parameter logic [CODE_W-1:0] RESET_CODE = CODE_W'(AFC_RESET_CODE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              afc_start,
  input  logic              fb_pulse,
  input  logic [CNT_W-1:0]  target_count,
  output logic [CODE_W-1:0] cap_code,
  output logic              afc_busy,
  output logic              afc_done
);

  localparam int IW  = (CODE_W > 1) ? $clog2(CODE_W) : 1;
  localparam int STW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  afc_state_e        state_q, state_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [IW-1:0]     bit_q, bit_d;
  logic [STW-1:0]    stmr_q, stmr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [CNT_W-1:0]  count;
  logic              win_done;
  logic              settle_done;
  logic              too_fast;
  logic [CODE_W-1:0] onehot;

  afc_freq_counter #(
    .CNT_W (CNT_W),
    .WINDOW(WINDOW)
  ) u_cnt (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (state_q == SETTLE),
    .enable_i     (state_q == COUNT),
    .pulse_i      (fb_pulse),
    .window_done_o(win_done),
    .count_o      (count)
  );

  assign settle_done = (state_q == SETTLE)
                    && (stmr_q == STW'(SETTLE_CYC - 1));
  assign too_fast    = count > target_count;
  assign onehot      = CODE_W'(1) << bit_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      code_q  <= RESET_CODE;
      bit_q   <= '0;
      stmr_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      bit_q   <= bit_d;
      stmr_q  <= stmr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (afc_start) state_d = SETTLE;
      SETTLE:  if (settle_done) state_d = COUNT;
      COUNT:   if (win_done) state_d = DECIDE;
      DECIDE:  state_d = (bit_q == '0) ? IDLE : SETTLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    code_d = code_q;
    bit_d  = bit_q;
    busy_d = busy_q;
    done_d = done_q;
    stmr_d = (state_q == SETTLE) ? stmr_q + 1'b1 : '0;
    unique case (1'b1)
      (state_q == IDLE) && afc_start: begin
        code_d = CODE_W'(1) << (CODE_W - 1);
        bit_d  = IW'(CODE_W - 1);
        busy_d = 1'b1;
        done_d = 1'b0;
      end
      state_q == DECIDE: begin
        // Equality counts as not too fast, so the trial bit drops
        code_d = too_fast ? code_q : (code_q & ~onehot);
        if (bit_q != '0) begin
          code_d = code_d | (onehot >> 1);
          bit_d  = bit_q - 1'b1;
        end else begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign cap_code = code_q;
  assign afc_busy = busy_q;
  assign afc_done = done_q;

endmodule

// File: tb/tb_afc_controller.sv
// Randomized bench for afc_controller with a trial-level behavioural model.
// A plant VCO emits (511 - code) pulses per window; a second instance runs saturated.
module tb_afc_controller;

  localparam int S = 64;
  localparam int W = 512;
  localparam int P = S + W + 1;
  localparam int L = 9 * P;

  logic       clk;
  logic       rst;
  logic       afc_start;
  logic       fb_pulse;
  logic [9:0] target_count;
  logic [8:0] cap_code;
  logic       afc_busy;
  logic       afc_done;

  logic       fb2;
  logic [7:0] target2;
  logic [8:0] cap2;
  logic       busy2;
  logic       done2;

  int errors = 0;
  int checks = 0;
  int busy_cnt = 0;
  int busy_cnt2 = 0;
  bit chk_en = 0;

  bit         m_active;
  bit         m_done;
  int         m_t;
  logic [8:0] m_code;
  logic [8:0] m_res;

  afc_controller dut (
    .clk         (clk),
    .rst         (rst),
    .afc_start   (afc_start),
    .fb_pulse    (fb_pulse),
    .target_count(target_count),
    .cap_code    (cap_code),
    .afc_busy    (afc_busy),
    .afc_done    (afc_done)
  );

  afc_controller #(.CNT_W(8)) dut_sat (
    .clk         (clk),
    .rst         (rst),
    .afc_start   (afc_start),
    .fb_pulse    (fb2),
    .target_count(target2),
    .cap_code    (cap2),
    .afc_busy    (busy2),
    .afc_done    (done2)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Largest code whose (saturated) pulse count beats the target, else 0
  function automatic logic [8:0] ref_result(input int tgt, input int cmax);
    int best = 0;
    for (int c = 0; c < 512; c++) begin
      int n = 511 - c;
      if (n > cmax) n = cmax;
      if (n > tgt) best = c;
    end
    return 9'(best);
  endfunction

  // Trial j shows resolved result bits above bit 8-j, bit 8-j set, rest zero
  function automatic logic [8:0] exp_code();
    logic [8:0] m;
    int j;
    if (!m_active) return m_code;
    j = m_t / P;
    m = 9'h1FF;
    m = m << (9 - j);
    return (m_res & m) | (9'h1 << (8 - j));
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active <= 0;
      m_done   <= 0;
      m_t      <= 0;
      m_code   <= 9'h100;
    end else if (m_active) begin
      m_t <= m_t + 1;
      if (m_t + 1 == L) begin
        m_active <= 0;
        m_done   <= 1;
        m_code   <= m_res;
      end
    end else if (afc_start) begin
      m_active <= 1;
      m_t      <= 0;
      m_done   <= 0;
      m_res    <= ref_result(int'(target_count), 1023);
    end
  end

  // Plant: pulses at the start of each count window, noise elsewhere
  always @(negedge clk) begin
    int p;
    p = m_t % P;
    if (m_active && p >= S && p < S + W)
      fb_pulse = (p - S) < (511 - int'(exp_code()));
    else
      fb_pulse = 1'($urandom % 2);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cap_code", 32'(cap_code), 32'(exp_code()));
      chk("afc_busy", 32'(afc_busy), 32'(m_active));
      chk("afc_done", 32'(afc_done), 32'(m_done));
      if (afc_busy) busy_cnt++;
      if (busy2) busy_cnt2++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (m_active && n < L + 20) begin
      tick(1);
      n++;
    end
    if (m_active) begin
      errors++;
      $display("FAIL timeout: calibration still running after %0d cycles", n);
    end
    tick(1);
  endtask

  // mode 0: single pulse, 1: extra pulse mid-run, 2: start held 3 cycles
  task automatic run(input int tgt, input int mode, input int lit);
    target_count = 10'(tgt);
    busy_cnt = 0;
    afc_start = 1;
    tick(mode == 2 ? 3 : 1);
    afc_start = 0;
    if (mode == 1) begin
      tick(1000);
      afc_start = 1;
      tick(1);
      afc_start = 0;
    end
    wait_idle();
    chk("busy_cycles", 32'(busy_cnt), 32'd5193);
    chk("done_final", 32'(afc_done), 32'd1);
    if (lit >= 0) chk("result", 32'(cap_code), 32'(lit));
    tick($urandom_range(3, 12));
  endtask

  initial begin
    int n;
    rst = 0;
    afc_start = 0;
    target_count = 0;
    fb2 = 1;
    target2 = 8'd254;
    #1 rst = 1;
    #1 chk_en = 1;
    tick(3);
    chk("rst_code", 32'(cap_code), 32'h100);
    chk("rst_busy", 32'(afc_busy), 32'd0);
    chk("rst_done", 32'(afc_done), 32'd0);
    rst = 0;
    tick(2);

    busy_cnt2 = 0;
    run(200, 0, 9'h136);
    chk("sat_result", 32'(cap2), 32'h1FF);
    chk("sat_done", 32'(done2), 32'd1);
    chk("sat_busy_cycles", 32'(busy_cnt2), 32'd5193);

    run(511, 0, 0);
    run(0, 0, 9'h1FE);
    run(200, 2, 9'h136);
    run($urandom_range(0, 600), 1, -1);

    target_count = 10'd200;
    afc_start = 1;
    tick(1);
    afc_start = 0;
    n = 0;
    while (m_t != 3 * P + S + 100 && n < L) begin
      tick(1);
      n++;
    end
    rst = 1;
    #1;
    chk("abort_code", 32'(cap_code), 32'h100);
    chk("abort_busy", 32'(afc_busy), 32'd0);
    chk("abort_done", 32'(afc_done), 32'd0);
    tick(2);
    rst = 0;
    tick(3);

    run($urandom_range(0, 600), 0, -1);
    run(300, 0, 9'hD2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/afc_controller.md
Name: afc_controller

Overview:
- Automatic frequency calibration (AFC) engine for the ETROC2 PLL model.
- Runs a 9-bit successive-approximation (SAR) search over the VCO capacitor-bank code. Each trial counts feedback pulses over a fixed reference window and compares the count with a programmed target.
- Sits directly upstream of the capacitor-code bit protector. It drives that stage's code input (cap_code) and busy flag (afc_busy).
- The bit protector captures cap_code when afc_busy falls, so the final code must be stable at that moment.

Parameters:
- CODE_W, 9, width of the capacitor-bank code.
- CNT_W, 10, width of the feedback-pulse counter and of target_count.
- SETTLE_CYC, 64, clk cycles allowed for VCO settling after each code change (legal range ≥1).
- WINDOW, 512, clk cycles per counting window (legal range ≥1).
- RESET_CODE, 9'h100, cap_code value after reset (mid-scale).

Ports:
- clk  in  1  reference clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- afc_start  in  1  single-cycle start request.
- fb_pulse  in  1  one-cycle pulse per divided VCO period, already synchronous to clk.
- target_count  in  CNT_W  expected pulse count per window; must be static while afc_busy is high.
- cap_code  out  CODE_W  capacitor-bank code to the bit protector.
- afc_busy  out  1  high while a calibration is running.
- afc_done  out  1  high from completion until the next accepted start.

Behaviour:
- Reset (async, immediate): state=IDLE, cap_code=RESET_CODE, afc_busy=0, afc_done=0, all counters 0.
- Reset mid-calibration aborts the calibration. Outputs return to reset values with no clock required.
- States: IDLE, SETTLE, COUNT, DECIDE.
- IDLE + afc_start=1 at edge k:
  - state→SETTLE, bit index i=CODE_W-1.
  - cap_code←only bit i set (9'h100).
  - afc_busy←1, afc_done←0, timer←0.
- afc_start is ignored outside IDLE.
- SETTLE: lasts exactly SETTLE_CYC cycles; fb_pulse is ignored. Then state→COUNT with count cleared.
- COUNT: lasts exactly WINDOW cycles.
  - Each cycle with fb_pulse=1 increments count.
  - count saturates at 2^CNT_W-1 and never wraps.
- DECIDE: one cycle.
  - If count > target_count (VCO still too fast), keep bit i; otherwise clear it. Equality clears the bit.
  - If i>0: set bit i-1, i←i-1, state→SETTLE.
  - If i=0: state→IDLE, afc_busy←0, afc_done←1.
  - At the i=0 decision, the final cap_code, afc_busy=0 and afc_done=1 all update on the same edge.
- Calibration latency: afc_busy is high for exactly CODE_W·(SETTLE_CYC+WINDOW+1) cycles.
- cap_code only changes at the start edge and at DECIDE edges. It is held indefinitely in IDLE.
- Lower-order bits are 0 at each trial; resolved higher bits are kept.
- Result: the largest code for which the trial count exceeds target_count, assuming frequency falls monotonically as the code rises. If no code qualifies, the result is 0.
- The comparison is unsigned and CNT_W bits wide; no other arithmetic is performed.

Decomposition:
- Shared package afc_pkg:
  - state enum (IDLE/SETTLE/COUNT/DECIDE);
  - default CODE_W, CNT_W and RESET_CODE constants;
  - a latency helper function.
- One natural sub-module, afc_freq_counter:
  - window timer plus saturating pulse counter;
  - inputs: clear and enable; outputs: window_done and count.
  - The FSM, SAR register and comparator stay in afc_controller.

Test Plan:
- Defaults, bench VCO model issues (511 − cap_code) pulses per window, target_count=200, one start → cap_code=9'h136 (310), afc_done=1, afc_busy high for exactly 9·577=5193 cycles.
- Same model, target_count=511 → cap_code=0. Same model, target_count=0 → cap_code=9'h1FE (510).
- CNT_W=8, WINDOW=512, fb_pulse held high, target_count=254 → count saturates at 255, every bit kept, cap_code=9'h1FF.
- afc_start pulsed again mid-calibration, and held high for 3 cycles at start → result and latency identical to a single-start run.
- Assert rst during the 4th bit's COUNT phase → cap_code=9'h100, afc_busy=0, afc_done=0 immediately. A new start afterwards gives a full correct calibration.
- Check cap_code is unchanged between the last DECIDE edge and the next start. Check cap_code never changes in SETTLE or COUNT. Check afc_done falls on the edge that accepts a new start.
